// File: rtl/rhythm_lane_engine.sv
// -----------------------------------------------------------------------------
// rhythm_lane_engine
//
// Purpose
//   Note-field and scoring core for a LANES-wide rhythm game. A LANES x DEPTH
//   note field scrolls one row toward the hit row (row 0) on every stepTick.
//   Player key chords are judged against row 0. The block keeps score, combo,
//   max combo and an elapsed-seconds timer, and raises gameOver when play time
//   runs out.
//
// Ports
//   sysClock  in   1              system clock, all logic on the rising edge
//   reset     in   1              synchronous, active-high
//   state     in   2              0 idle/clear, 1 play, 2 result, 3 hold
//   enter     in   LANES          debounced key levels
//   stepTick  in   1              one-cycle scroll pulse (sysClock domain)
//   random    in   LANES          new top-row pattern, taken on stepTick
//   cord      out  LANES*DEPTH    note field, row r = cord[r*LANES +: LANES]
//   score     out  SCORE_W        hits plus bonus, saturating
//   combo     out  COMBO_W        consecutive clean rows, saturating
//   maxCombo  out  COMBO_W        highest combo this game
//   timer     out  8              elapsed seconds
//   gameOver  out  1              set once timer reaches GAME_SECONDS
//   number    out  SCORE_W        result display value (score or timer)
//
// Configuration
//   COMBO_BONUS_EN  when defined, each clean row scores 1 + (combo >> 3)
//                   instead of 1. When undefined no bonus logic exists.
//
// Handshake note
//   There are no valid/ready pairs here. stepTick is a single-cycle strobe,
//   and enter is a level whose changes (enter != enter_prev) form key events.
// -----------------------------------------------------------------------------
module rhythm_lane_engine #(
  parameter int LANES         = 3,
  parameter int DEPTH         = 4,
  parameter int TICKS_PER_SEC = 1000000,
  parameter int GAME_SECONDS  = 60,
  parameter int SCORE_W       = 16,
  parameter int COMBO_W       = 12
) (
  input  logic                     sysClock,
  input  logic                     reset,
  input  logic [1:0]               state,
  input  logic [LANES-1:0]         enter,
  input  logic                     stepTick,
  input  logic [LANES-1:0]         random,
  output logic [LANES*DEPTH-1:0]   cord,
  output logic [SCORE_W-1:0]       score,
  output logic [COMBO_W-1:0]       combo,
  output logic [COMBO_W-1:0]       maxCombo,
  output logic [7:0]               timer,
  output logic                     gameOver,
  output logic [SCORE_W-1:0]       number
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  // Sum is wide enough that neither the score nor a bonus increment can wrap
  // before the saturation compare sees it.
  localparam int SUM_W = ((SCORE_W > COMBO_W) ? SCORE_W : COMBO_W) + 2;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]       TIMER_END = 8'(GAME_SECONDS);
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // ---------------------------------------------------------------------------
  // Internal state
  // ---------------------------------------------------------------------------
  logic [LANES-1:0] enter_prev;
  logic             wrong;        // a bad press already happened on this row
  logic [PRE_W-1:0] prescaler;
  logic             show_score;   // result display selects score (1) or timer (0)

  // ---------------------------------------------------------------------------
  // Combinational judge path
  // ---------------------------------------------------------------------------
  logic                   key_event;
  logic [LANES-1:0]       row0;
  logic [LANES-1:0]       row0_after_key;
  logic                   wrong_after_key;
  logic                   clean;
  logic [SUM_W-1:0]       inc_w;
  logic [SUM_W-1:0]       score_sum;
  logic [SCORE_W-1:0]     score_next;
  logic [COMBO_W-1:0]     combo_next;
  logic [COMBO_W-1:0]     max_next;
  logic [LANES*DEPTH-1:0] cord_after_key;
  logic [LANES*DEPTH-1:0] cord_shift;
  logic                   pre_terminal;
  logic [7:0]             timer_next;
  logic                   score_toggle;

  assign key_event = (enter != enter_prev);
  assign row0      = cord[LANES-1:0];

  // Key judgement happens first; the scroll judge below sees its result in
  // the same cycle, so a press and a stepTick together still count as a hit.
  always_comb begin
    row0_after_key  = row0;
    wrong_after_key = wrong;
    if (key_event && !wrong) begin
      if (enter == row0) begin
        // Also covers releasing keys after a hit: all-zero matches the
        // already-cleared row, so no penalty.
        row0_after_key = '0;
      end else begin
        wrong_after_key = 1'b1;
      end
    end
  end

  always_comb begin
    cord_after_key            = cord;
    cord_after_key[LANES-1:0] = row0_after_key;
  end

  // Row r takes row r+1; the top row takes the new random pattern.
  always_comb begin
    cord_shift = '0;
    for (int r = 0; r < DEPTH - 1; r++) begin
      cord_shift[r*LANES +: LANES] = cord_after_key[(r+1)*LANES +: LANES];
    end
    cord_shift[(DEPTH-1)*LANES +: LANES] = random;
  end

  // An empty row with no presses is clean too.
  assign clean = !wrong_after_key && (row0_after_key == '0);

`ifdef COMBO_BONUS_EN
  // One extra point for every 8 combo held before this row.
  assign inc_w = SUM_W'(1) + (SUM_W'(combo) >> 3);
`else
  assign inc_w = SUM_W'(1);
`endif

  assign score_sum  = SUM_W'(score) + inc_w;
  assign score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_comb begin
    combo_next = '0;
    if (clean) begin
      combo_next = (combo == COMBO_MAX) ? combo : combo + COMBO_W'(1);
    end
  end

  assign max_next = (combo_next > maxCombo) ? combo_next : maxCombo;

  assign pre_terminal = (prescaler == PRE_LAST);
  assign timer_next   = timer + 8'd1;

  // Only a rising edge of the leftmost key flips the result display.
  assign score_toggle = key_event && enter[LANES-1] && !enter_prev[LANES-1];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysClock) begin
    if (reset || (state == ST_IDLE)) begin
      cord       <= '0;
      score      <= '0;
      combo      <= '0;
      maxCombo   <= '0;
      timer      <= '0;
      gameOver   <= 1'b0;
      number     <= '0;
      enter_prev <= '0;
      wrong      <= 1'b0;
      prescaler  <= '0;
      show_score <= 1'b1;
    end else begin
      enter_prev <= enter;
      case (state)
        ST_PLAY: begin
          // After game over the whole play path is frozen.
          if (!gameOver) begin
            cord  <= cord_after_key;
            wrong <= wrong_after_key;
            if (stepTick) begin
              score    <= clean ? score_next : score;
              combo    <= combo_next;
              maxCombo <= max_next;
              cord     <= cord_shift;
              wrong    <= 1'b0;
            end
            if (pre_terminal) begin
              prescaler <= '0;
              timer     <= timer_next;
              if (timer_next == TIMER_END) begin
                gameOver <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
          end
        end
        ST_RESULT: begin
          if (score_toggle) begin
            show_score <= !show_score;
          end
          number <= show_score ? score : SCORE_W'(timer);
        end
        ST_HOLD: begin
          // Pause: everything except enter_prev holds.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rhythm_lane_engine.sv
// -----------------------------------------------------------------------------
// tb_rhythm_lane_engine
//
// Directed bench for rhythm_lane_engine with LANES=3, DEPTH=4, a short
// second (16 clocks) and 20-second games, and 8-bit score/combo so that
// saturation is reachable in a few hundred cycles. Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point, so every
// check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_rhythm_lane_engine;

  localparam int LANES = 3;
  localparam int DEPTH = 4;
  localparam int TPS   = 16;
  localparam int GSEC  = 20;
  localparam int SW    = 8;
  localparam int CW    = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [1:0]             state;
  logic [LANES-1:0]       enter;
  logic                   step_tick;
  logic [LANES-1:0]       random;
  logic [LANES*DEPTH-1:0] cord;
  logic [SW-1:0]          score;
  logic [CW-1:0]          combo;
  logic [CW-1:0]          max_combo;
  logic [7:0]             timer;
  logic                   game_over;
  logic [SW-1:0]          number;

  rhythm_lane_engine #(
    .LANES(LANES), .DEPTH(DEPTH), .TICKS_PER_SEC(TPS), .GAME_SECONDS(GSEC),
    .SCORE_W(SW), .COMBO_W(CW)
  ) dut (
    .sysClock (clk),
    .reset    (reset),
    .state    (state),
    .enter    (enter),
    .stepTick (step_tick),
    .random   (random),
    .cord     (cord),
    .score    (score),
    .combo    (combo),
    .maxCombo (max_combo),
    .timer    (timer),
    .gameOver (game_over),
    .number   (number)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of state 0 wipes the game; play starts on the next edge.
  task automatic clear_game();
    state = 2'd0; enter = '0; step_tick = 1'b0; random = '0;
    tick();
    state = 2'd1;
  endtask

  // Scrolls pattern p into row 0. The four scroll ticks judge empty rows,
  // so the game is left at score 4, combo 4, prescaler 4.
  task automatic load_row0(input logic [LANES-1:0] p);
    clear_game();
    step_tick = 1'b1; random = p;
    tick();
    random = '0;
    repeat (3) tick();
    step_tick = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int m_score;
  int m_combo;
  int inc;
  logic [SW-1:0] exp_v;

  initial begin
    reset = 1'b1; state = 2'd0; enter = '0; step_tick = 1'b0; random = '0;
    tick();
    tick();
    check_eq("rst_score", score, 0);
    check_eq("rst_combo", combo, 0);
    check_eq("rst_cord", cord, 0);
    check_eq("rst_game_over", game_over, 0);
    reset = 1'b0;

    // --- Build score 5 / combo 3 / timer 7, then reset mid-play ---
    clear_game();
    step_tick = 1'b1; random = '0; enter = '0;
    tick(); tick();                       // two empty clean rows: 2 / 2
    enter = 3'b001; tick();               // press on an empty row: wrong
    check_eq("t1_wrong_combo", combo, 0);
    check_eq("t1_wrong_score", score, 2);
    tick(); tick();                       // 4 / 2
    random = 3'b101; tick();              // 5 / 3, pattern enters top row
    step_tick = 1'b0; random = '0;
    repeat (106) tick();                  // 112 play cycles = 7 seconds
    check_eq("t1_timer", timer, 7);
    check_eq("t1_score", score, 5);
    check_eq("t1_combo", combo, 3);
    check_eq("t1_max", max_combo, 3);
    check_eq("t1_cord", cord, 12'hA00);
    state = 2'd2; tick();
    check_eq("t1_number_score", number, 5);
    enter = 3'b101; tick();               // leftmost key rises: toggle
    check_eq("t1_number_lat", number, 5);
    tick();
    check_eq("t1_number_timer", number, 7);
    state = 2'd1; tick();
    check_eq("t1_number_hold", number, 7);
    reset = 1'b1; tick();
    reset = 1'b0;
    check_eq("t1_rst_score", score, 0);
    check_eq("t1_rst_combo", combo, 0);
    check_eq("t1_rst_max", max_combo, 0);
    check_eq("t1_rst_timer", timer, 0);
    check_eq("t1_rst_cord", cord, 0);
    check_eq("t1_rst_number", number, 0);

    // --- Clean hit then release, then scroll ---
    load_row0(3'b101);
    check_eq("t2_loaded", cord, 12'h005);
    check_eq("t2_base_score", score, 4);
    enter = 3'b101; tick();
    check_eq("t2_row0_clear", cord, 0);
    enter = 3'b000; tick();
    step_tick = 1'b1; tick();
    step_tick = 1'b0;
    check_eq("t2_score", score, 5);
    check_eq("t2_combo", combo, 5);
    check_eq("t2_max", max_combo, 5);

    // --- Partial chord is wrong; later correct chord is ignored ---
    load_row0(3'b011);
    enter = 3'b001; tick();
    check_eq("t3_cord_kept", cord, 12'h003);
    enter = 3'b011; tick();
    check_eq("t3_late_ignored", cord, 12'h003);
    enter = 3'b000; step_tick = 1'b1; tick();
    check_eq("t3_combo", combo, 0);
    check_eq("t3_score", score, 4);
    check_eq("t3_max", max_combo, 4);
    check_eq("t3_cord", cord, 0);
    tick();                               // wrong cleared by the scroll
    step_tick = 1'b0;
    check_eq("t3_recover_score", score, 5);
    check_eq("t3_recover_combo", combo, 1);

    // --- Unpressed note is a miss ---
    load_row0(3'b010);
    step_tick = 1'b1; tick();
    step_tick = 1'b0;
    check_eq("miss_combo", combo, 0);
    check_eq("miss_score", score, 4);

    // --- Press and scroll in the same cycle, then pause ---
    load_row0(3'b110);
    enter = 3'b110; step_tick = 1'b1; tick();
    check_eq("t4_score", score, 5);
    check_eq("t4_combo", combo, 5);
    check_eq("t4_cord", cord, 0);
    state = 2'd3; random = 3'b111; enter = 3'b000;
    repeat (3) tick();
    check_eq("hold_cord", cord, 0);
    check_eq("hold_score", score, 5);
    check_eq("hold_combo", combo, 5);
    state = 2'd1; step_tick = 1'b0; random = '0;
    repeat (10) tick();                   // prescaler 5 -> 15
    check_eq("hold_timer_before", timer, 0);
    tick();
    check_eq("hold_timer_after", timer, 1);

    // --- Combo bonus and saturation ---
    clear_game();
    step_tick = 1'b1; random = '0;
    repeat (8) tick();
    check_eq("bonus_pre_score", score, 8);
    check_eq("bonus_pre_combo", combo, 8);
    tick();
`ifdef COMBO_BONUS_EN
    check_eq("bonus_score", score, 10);
    m_score = 10;
`else
    check_eq("bonus_score", score, 9);
    m_score = 9;
`endif
    m_combo = 9;
    for (int i = 0; i < 250; i++) begin
      inc = 1;
`ifdef COMBO_BONUS_EN
      inc = 1 + (m_combo / 8);
`endif
      m_score = (m_score + inc > 255) ? 255 : m_score + inc;
      m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
      exp_q.push_back(SW'(m_score));
      tick();
      exp_v = exp_q.pop_front();
      check_eq($sformatf("sat_score_%0d", i), score, exp_v);
    end
    step_tick = 1'b0;
    check_eq("sat_score_final", score, 255);
    check_eq("sat_combo_final", combo, 255);
    check_eq("sat_max_final", max_combo, 255);

    // --- Game over after GSEC seconds; field and score freeze ---
    clear_game();
    repeat (318) tick();
    step_tick = 1'b1; random = 3'b101; tick();
    step_tick = 1'b0; random = '0;
    check_eq("go_timer_19", timer, 19);
    check_eq("go_not_yet", game_over, 0);
    check_eq("go_score_pre", score, 1);
    tick();
    check_eq("go_set", game_over, 1);
    check_eq("go_timer_20", timer, 20);
    step_tick = 1'b1; random = 3'b111;
    enter = 3'b111; tick();
    enter = 3'b000; tick();
    enter = 3'b010; tick();
    tick();
    step_tick = 1'b0;
    check_eq("go_cord_frozen", cord, 12'hA00);
    check_eq("go_score_frozen", score, 1);
    check_eq("go_combo_frozen", combo, 1);
    check_eq("go_timer_frozen", timer, 20);
    check_eq("go_still_over", game_over, 1);

    // --- Final report ---
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
